// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter: access size codes,
// arbiter FSM states, requester ids and the alignment rule used by the
// optional misalignment trap (DMEM_MISALIGN_TRAP_EN).
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic PORT_M0 = 1'b0;
  localparam logic PORT_M1 = 1'b1;

  // A half must sit on an even byte, a word (or reserved size) on a word boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for one RAM access: byte enables and replicated store
// data on the way out, lane extraction plus sign/zero extension on the way in.
// Purely combinational. Reserved size 2'b11 behaves as a word.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

  // Select lanes by access size; misaligned low bits are simply ignored here.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = ext_byte(rdata[8*addr_lo +: 8], sign);
      end
      SZ_H: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = ext_half(rdata[16*addr_lo[1] +: 16], sign);
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single-port data RAM (m0 = CPU LSU, m1 = DMA/debug).
// Round-robin grant in IDLE, one access in flight, RAM read latency RAM_LAT (1..3)
// absorbed in WAIT. Optional macro DMEM_MISALIGN_TRAP_EN rejects misaligned
// half/word accesses with an error response instead of touching the RAM.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int RAM_LAT = 1,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [1:0]    m0_size,
  input  logic          m0_sign,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [1:0]    m1_size,
  input  logic          m1_sign,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          m1_err,
  output logic          ram_en,
  output logic          ram_we,
  output logic [3:0]    ram_be,
  output logic [AW-3:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

  state_t        state, state_next;
  logic [1:0]    cnt;
  logic          last;
  logic          owner;
  logic          grant;
  logic          pick;
  logic          trap;
  logic          capture;

  logic          sel_we;
  logic [1:0]    sel_size;
  logic          sel_sign;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;

  logic          cmd_we;
  logic [1:0]    cmd_size;
  logic          cmd_sign;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [31:0]   res_data;

  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [31:0]   lane_rdata;

  // Round-robin pick and mux of the winning requester's command fields.
  always_comb begin
    if (m0_req && m1_req) pick = ~last;
    else                  pick = m1_req ? PORT_M1 : PORT_M0;
    grant     = (state == IDLE) && rst && (m0_req || m1_req);
    sel_we    = pick ? m1_we    : m0_we;
    sel_size  = pick ? m1_size  : m0_size;
    sel_sign  = pick ? m1_sign  : m0_sign;
    sel_addr  = pick ? m1_addr  : m0_addr;
    sel_wdata = pick ? m1_wdata : m0_wdata;
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = is_misaligned(sel_size, sel_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  // FSM state register; reset drops any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // FSM next state; capture marks the cycle the RAM read data is valid.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE:  if (grant) state_next = trap ? RESP : ISSUE;
      ISSUE: state_next = cmd_we ? RESP : WAIT;
      WAIT: begin
        if (cnt == LAT_LAST) begin
          state_next = RESP;
          capture    = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latency counter, restarted whenever the FSM is outside WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               cnt <= 2'd0;
    else if (state != WAIT) cnt <= 2'd0;
    else                    cnt <= cnt + 2'd1;
  end

  // Priority pointer and owner of the current access; reset favours m0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last  <= PORT_M1;
      owner <= PORT_M0;
    end else if (grant) begin
      last  <= pick;
      owner <= pick;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic res_err;
`endif

  // Command and result registers; outputs are gated by state so no reset is needed.
  always_ff @(posedge clk) begin
    if (grant) begin
      cmd_we    <= sel_we;
      cmd_size  <= sel_size;
      cmd_sign  <= sel_sign;
      cmd_addr  <= sel_addr;
      cmd_wdata <= sel_wdata;
      res_data  <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
      res_err   <= trap;
`endif
    end else if (capture) begin
      res_data  <= lane_rdata;
    end
  end

  dmem_lane u_lane (
    .size      (cmd_size),
    .addr_lo   (cmd_addr[1:0]),
    .sign      (cmd_sign),
    .wdata     (cmd_wdata),
    .rdata     (ram_rdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  assign m0_gnt    = grant && (pick == PORT_M0);
  assign m1_gnt    = grant && (pick == PORT_M1);
  assign m0_rvalid = (state == RESP) && (owner == PORT_M0);
  assign m1_rvalid = (state == RESP) && (owner == PORT_M1);
  assign m0_rdata  = m0_rvalid ? res_data : 32'd0;
  assign m1_rdata  = m1_rvalid ? res_data : 32'd0;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign m0_err = m0_rvalid && res_err;
  assign m1_err = m1_rvalid && res_err;
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

  assign ram_en    = (state == ISSUE);
  assign ram_we    = ram_en && cmd_we;
  assign ram_be    = ram_en ? lane_be : 4'b0000;
  assign ram_addr  = ram_en ? cmd_addr[AW-1:2] : '0;
  assign ram_wdata = ram_en ? lane_wdata : 32'd0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with RAM_LAT=3 and a read-only RAM model.
module tb_dmem_port_arbiter;

  localparam int LAT = 3;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int S_G0 = 0, S_G1 = 1, S_RV0 = 2, S_RV1 = 3, S_GANY = 4, S_RVANY = 5;

  logic        clk, rst;
  logic        m0_req, m0_we, m0_sign, m0_gnt, m0_rvalid, m0_err;
  logic [1:0]  m0_size;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_sign, m1_gnt, m1_rvalid, m1_err;
  logic [1:0]  m1_size;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        ram_en, ram_we;
  logic [3:0]  ram_be;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt = 0;
  int rv_cnt = 0;
  int viol = 0;

  logic [31:0] mem [0:255];
  logic [31:0] pipe [0:2];

  dmem_port_arbiter #(.RAM_LAT(LAT), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_sign(m0_sign),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_sign(m1_sign),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read data appears LAT cycles after ram_en; filler otherwise.
  always @(posedge clk) begin
    pipe[0] <= (ram_en && !ram_we) ? mem[ram_addr[7:0]] : 32'hDEAD_BEEF;
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign ram_rdata = pipe[LAT-1];

  // Event counters sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_en) en_cnt <= en_cnt + 1;
    if (m0_rvalid || m1_rvalid) rv_cnt <= rv_cnt + 1;
    if ((m0_gnt && m1_gnt) || (m0_rvalid && m1_rvalid) || ((m0_gnt || m1_gnt) && ram_en))
      viol <= viol + 1;
  end

  logic [31:0] flags, data_or;
  assign flags   = {20'd0, m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err,
                    ram_en, ram_we, ram_be};
  assign data_or = m0_rdata | m1_rdata | ram_wdata | {2'b00, ram_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic sigsel(input int s);
    case (s)
      S_G0:    return m0_gnt;
      S_G1:    return m1_gnt;
      S_RV0:   return m0_rvalid;
      S_RV1:   return m1_rvalid;
      S_GANY:  return m0_gnt | m1_gnt;
      S_RVANY: return m0_rvalid | m1_rvalid;
      default: return 1'b0;
    endcase
  endfunction

  // Returns the cycle index at which the selected signal is seen, -1 on timeout.
  task automatic wait_for(input int sel, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sigsel(sel)) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic drive(input int p, input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      m0_req = 1'b1; m0_we = we; m0_size = size; m0_sign = sign; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_size = size; m1_sign = sign; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int g, r, g2, r2, e0, rv0;
  int gk [0:3];
  logic who [0:3];

  initial begin
    rst = 1'b0;
    m0_req = 0; m0_we = 0; m0_size = 0; m0_sign = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_size = 0; m1_sign = 0; m1_addr = 0; m1_wdata = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 + i;
    mem[0] = 32'h8001_1234;
    mem[1] = 32'hCAFE_F00D;
    mem[4] = 32'h1234_5678;
    mem[5] = 32'hB333_4444;

    // Reset state, with a request pending during reset.
    repeat (3) step();
    drive(0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("reset_flags", flags, 32'h0);
    check("reset_data", data_or, 32'h0);
    step();
    m0_req = 0;
    rst = 1'b1;
    step();

    // m0 store byte 0xA5 at 0x103.
    drive(0, 1'b1, SZ_B, 1'b0, 32'h103, 32'h0000_00A5);
    wait_for(S_G0, 10, g);
    step();
    m0_req = 0;
    @(negedge clk);
    check("st_ram_en", {31'd0, ram_en}, 32'd1);
    check("st_ram_we", {31'd0, ram_we}, 32'd1);
    check("st_ram_be", {28'd0, ram_be}, 32'h8);
    check("st_ram_wdata", ram_wdata, 32'hA5A5_A5A5);
    check("st_ram_addr", {2'b00, ram_addr}, 32'h40);
    wait_for(S_RV0, 10, r);
    check("st_latency", r - g, 2);
    check("st_rdata", m0_rdata, 32'h0);

    // m1 half loads at 0x002, signed then unsigned.
    step();
    drive(1, 1'b0, SZ_H, 1'b1, 32'h002, 32'h0);
    wait_for(S_G1, 10, g);
    step();
    m1_req = 0;
    wait_for(S_RV1, 20, r);
    check("ldh_s_latency", r - g, LAT + 2);
    check("ldh_s_rdata", m1_rdata, 32'hFFFF_8001);
    check("ldh_s_err", {31'd0, m1_err}, 32'd0);
    step();
    drive(1, 1'b0, SZ_H, 1'b0, 32'h002, 32'h0);
    wait_for(S_G1, 10, g);
    step();
    m1_req = 0;
    wait_for(S_RV1, 20, r);
    check("ldh_u_latency", r - g, LAT + 2);
    check("ldh_u_rdata", m1_rdata, 32'h0000_8001);

    // Both ports requesting continuously: alternate grants starting with m0.
    step();
    e0 = en_cnt;
    drive(0, 1'b1, SZ_W, 1'b0, 32'h40, 32'h1111_1111);
    drive(1, 1'b1, SZ_W, 1'b0, 32'h44, 32'h2222_2222);
    for (int k = 0; k < 4; k++) begin
      wait_for(S_GANY, 10, gk[k]);
      who[k] = m1_gnt;
    end
    check("arb_win0", {31'd0, who[0]}, 32'd0);
    check("arb_win1", {31'd0, who[1]}, 32'd1);
    check("arb_win2", {31'd0, who[2]}, 32'd0);
    check("arb_win3", {31'd0, who[3]}, 32'd1);
    check("arb_spacing", gk[1] - gk[0], 3);
    step();
    m0_req = 0;
    m1_req = 0;
    wait_for(S_RVANY, 10, r);
    check("arb_last_rv_m1", {31'd0, m1_rvalid}, 32'd1);
    step();
    check("arb_en_count", en_cnt - e0, 4);

    // Misaligned word load at 0x006.
    e0 = en_cnt;
    drive(0, 1'b0, SZ_W, 1'b0, 32'h006, 32'h0);
    wait_for(S_G0, 10, g);
    step();
    m0_req = 0;
    wait_for(S_RV0, 20, r);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("mis_latency", r - g, 1);
    check("mis_rdata", m0_rdata, 32'h0);
    check("mis_err", {31'd0, m0_err}, 32'd1);
    step();
    check("mis_en_count", en_cnt - e0, 0);
`else
    check("mis_latency", r - g, LAT + 2);
    check("mis_rdata", m0_rdata, 32'hCAFE_F00D);
    check("mis_err", {31'd0, m0_err}, 32'd0);
    step();
    check("mis_en_count", en_cnt - e0, 1);
`endif

    // Back-to-back m0 loads: word at 0x010, then signed byte at 0x017.
    drive(0, 1'b0, SZ_W, 1'b0, 32'h010, 32'h0);
    wait_for(S_G0, 10, g);
    step();
    drive(0, 1'b0, SZ_B, 1'b1, 32'h017, 32'h0);
    wait_for(S_RV0, 20, r);
    check("b2b_1_latency", r - g, LAT + 2);
    check("b2b_1_rdata", m0_rdata, 32'h1234_5678);
    wait_for(S_G0, 10, g2);
    check("b2b_gnt_after_rv", g2 - r, 1);
    step();
    m0_req = 0;
    wait_for(S_RV0, 20, r2);
    check("b2b_2_latency", r2 - g2, LAT + 2);
    check("b2b_2_rdata", m0_rdata, 32'hFFFF_FFB3);

    // Reset while an m1 load waits for RAM data.
    step();
    drive(1, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
    wait_for(S_G1, 10, g);
    step();
    m1_req = 0;
    step();
    rv0 = rv_cnt;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_flags", flags, 32'h0);
    check("midrst_data", data_or, 32'h0);
    repeat (2) step();
    rst = 1'b1;
    repeat (LAT + 3) step();
    check("midrst_no_rvalid", rv_cnt - rv0, 0);
    drive(1, 1'b1, SZ_H, 1'b0, 32'h022, 32'h0000_BEEF);
    wait_for(S_G1, 5, g);
    check("post_rst_gnt_seen", {31'd0, g >= 0}, 32'd1);
    step();
    m1_req = 0;
    @(negedge clk);
    check("post_rst_be", {28'd0, ram_be}, 32'hC);
    check("post_rst_wdata", ram_wdata, 32'hBEEF_BEEF);
    wait_for(S_RV1, 10, r);
    check("post_rst_latency", r - g, 2);

    step();
    check("no_overlap", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
